// File: rtl/imem_stream_loader_pkg.sv
// Shared loader definitions: state codes and default memory depth for the
// instruction-memory stream loader.
package imem_stream_loader_pkg;

    localparam int unsigned LD_DEPTH = 512;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2,
        LD_ERR  = 2'd3
    } ld_state_e;

    // True when the byte being accepted brings the count to a multiple of 4.
    function automatic logic completes_word(input logic [1:0] count_lsbs);
        return count_lsbs == 2'b11;
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// DEPTH x 8 byte memory: one synchronous write port and one combinational
// big-endian 32-bit read port with mod-DEPTH byte indexing.
module imem_byte_ram
    import imem_stream_loader_pkg::*;
#(
    parameter int unsigned DEPTH = LD_DEPTH,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // AW-bit adds wrap naturally, giving mod-DEPTH indexing for a power-of-two DEPTH.
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [AW-1:0] raddr3;

    always_comb begin
        raddr1 = raddr + AW'(1);
        raddr2 = raddr + AW'(2);
        raddr3 = raddr + AW'(3);
        rdata  = {mem[raddr], mem[raddr1], mem[raddr2], mem[raddr3]};
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Fills the instruction memory from a valid/ready byte stream starting at
// address 0 and holds instruction fetch off until a well-formed image is loaded.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter int unsigned DEPTH = LD_DEPTH,
    parameter int unsigned AW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic [AW-1:0] fetch_addr,
    output logic [31:0]   fetch_data,
    output logic          fetch_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   byte_count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

    ld_state_e     state;
    logic [AW-1:0] addr;
    logic          xfer;
    logic          we;

    // start takes priority over a coincident byte, so ready drops in that cycle.
    always_comb begin
        in_ready = (state == LD_LOAD) && !start;
        xfer     = in_ready && in_valid;
        we       = xfer && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_IDLE;
            addr       <= '0;
            byte_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            fetch_hold <= 1'b1;
        end else if (start) begin
            state      <= LD_LOAD;
            addr       <= '0;
            byte_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            fetch_hold <= 1'b1;
        end else if (xfer) begin
            addr       <= addr + AW'(1);
            byte_count <= byte_count + CNT_ONE;
            if (in_last) begin
                if (completes_word(byte_count[1:0])) begin
                    state      <= LD_DONE;
                    load_done  <= 1'b1;
                    fetch_hold <= 1'b0;
                end else begin
                    state    <= LD_ERR;
                    load_err <= 1'b1;
                end
            end else if (addr == LAST_ADDR) begin
                // Memory full without a last marker: overflow, never wrap writes.
                state    <= LD_ERR;
                load_err <= 1'b1;
            end
        end
    end

    imem_byte_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(addr),
        .wdata(in_data),
        .raddr(fetch_addr),
        .rdata(fetch_data)
    );

endmodule
